// File: rtl/branch_feedback_queue_pkg.sv
// Shared types for the branch-outcome path between ROB, fetch and predictor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package branch_feedback_queue_pkg;

  localparam int ADDR_WIDTH = 32;

  // Branch outcome encoding shared by ROB, IF and predictor
  localparam logic BR_NOT_TAKEN = 1'b0;
  localparam logic BR_TAKEN     = 1'b1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic                  taken;
  } bfq_entry_t;

  localparam int ENTRY_WIDTH = $bits(bfq_entry_t);

endpackage

// File: rtl/branch_feedback_queue_storage.sv
// Register array holding queued branch outcomes; one write port, one async read port.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the caller guarantees it never overwrites a live entry.
module bfq_storage #(
  parameter int DEPTH_WIDTH = 3,
  parameter int WIDTH       = 33
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [DEPTH_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic [DEPTH_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]       rd_data
);

  logic [WIDTH-1:0] mem [0:(1<<DEPTH_WIDTH)-1];

  // Contents are meaningless until written, so the array carries no reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/branch_feedback_queue.sv
// Queues committed branch outcomes and replays them in order whenever the predictor is idle.
// Latency: an entry pushed at edge N can be presented in cycle N+1 at the earliest (no bypass).
// Backpressure: FQROB_full blocks ROB commits; FQIF_stall_req asks IF to yield after prolonged starvation.
module branch_feedback_queue
  import branch_feedback_queue_pkg::*;
#(
  parameter int DEPTH_WIDTH  = 3,
  parameter int DEPTH        = 1 << DEPTH_WIDTH,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  Sys_clk,
  input  logic                  Sys_rst,
  input  logic                  Sys_rdy,
  input  logic                  ROBFQ_commit_en,
  input  logic                  ROBFQ_branch_result,
  input  logic [ADDR_WIDTH-1:0] ROBFQ_pc,
  output logic                  FQROB_full,
  input  logic                  IFPD_predict_en,
  output logic                  FQPD_feedback_en,
  output logic                  FQPD_branch_result,
  output logic [ADDR_WIDTH-1:0] FQPD_feedback_pc,
  output logic                  FQIF_stall_req,
  output logic                  FQ_overflow,
  output logic [DEPTH_WIDTH:0]  FQ_count
);

  localparam logic [DEPTH_WIDTH:0] FULL_COUNT = (DEPTH_WIDTH+1)'(DEPTH);
  localparam logic [3:0]           STARVE_MAX = 4'(STARVE_LIMIT);

  logic [DEPTH_WIDTH-1:0] head;
  logic [DEPTH_WIDTH-1:0] tail;
  logic [DEPTH_WIDTH:0]   count;
  logic [3:0]             starve;
  logic                   overflow;

  logic       empty;
  logic       full;
  logic       push;
  logic       pop;
  logic       drop;
  bfq_entry_t wr_entry;
  bfq_entry_t rd_entry;

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

  // A pop in the same cycle frees the slot the push needs, so a full queue still accepts it
  assign pop  = FQPD_feedback_en;
  assign push = ROBFQ_commit_en & Sys_rdy & (~full | pop);
  assign drop = ROBFQ_commit_en & Sys_rdy & full & ~pop;

  assign wr_entry.pc    = ROBFQ_pc;
  assign wr_entry.taken = ROBFQ_branch_result;

  bfq_storage #(
    .DEPTH_WIDTH (DEPTH_WIDTH),
    .WIDTH       (ENTRY_WIDTH)
  ) u_storage (
    .clk     (Sys_clk),
    .wr_en   (push),
    .wr_addr (tail),
    .wr_data (wr_entry),
    .rd_addr (head),
    .rd_data (rd_entry)
  );

  assign FQROB_full         = full;
  assign FQPD_feedback_en   = ~empty & ~IFPD_predict_en & Sys_rdy;
  assign FQPD_branch_result = empty ? BR_NOT_TAKEN : rd_entry.taken;
  assign FQPD_feedback_pc   = empty ? '0 : rd_entry.pc;
  assign FQIF_stall_req     = (starve == STARVE_MAX);
  assign FQ_overflow        = overflow;
  assign FQ_count           = count;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge Sys_clk or negedge Sys_rst) begin
    if (!Sys_rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Count consecutive cycles where a pending entry is blocked by a prediction request
  always_ff @(posedge Sys_clk or negedge Sys_rst) begin
    if (!Sys_rst) begin
      starve <= '0;
    end else if (Sys_rdy) begin
      if (pop || empty) begin
        starve <= '0;
      end else if (IFPD_predict_en && starve != STARVE_MAX) begin
        starve <= starve + 1'b1;
      end
    end
  end

  // Sticky record that the ROB committed into a full queue and an outcome was lost
  always_ff @(posedge Sys_clk or negedge Sys_rst) begin
    if (!Sys_rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_feedback_queue.sv
// Randomized and directed check of branch_feedback_queue against a queue-based model.
// Latency: n/a.
// Backpressure: n/a.
module tb_branch_feedback_queue;

  localparam int DEPTH        = 8;
  localparam int STARVE_LIMIT = 8;

  typedef struct {
    logic [31:0] pc;
    logic        t;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic        sys_rdy;
  logic        commit_en;
  logic        result;
  logic [31:0] pc_in;
  logic        full;
  logic        predict_en;
  logic        fb_en;
  logic        fb_res;
  logic [31:0] fb_pc;
  logic        stall;
  logic        ovf;
  logic [3:0]  count;

  int total = 0;
  int bad   = 0;

  ent_t mq[$];
  int   m_starve = 0;
  logic m_ovf    = 1'b0;

  branch_feedback_queue dut (
    .Sys_clk             (clk),
    .Sys_rst             (rst_n),
    .Sys_rdy             (sys_rdy),
    .ROBFQ_commit_en     (commit_en),
    .ROBFQ_branch_result (result),
    .ROBFQ_pc            (pc_in),
    .FQROB_full          (full),
    .IFPD_predict_en     (predict_en),
    .FQPD_feedback_en    (fb_en),
    .FQPD_branch_result  (fb_res),
    .FQPD_feedback_pc    (fb_pc),
    .FQIF_stall_req      (stall),
    .FQ_overflow         (ovf),
    .FQ_count            (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs mid-cycle, compare against the model, then advance both
  task automatic cyc(input logic c, input logic r, input logic [31:0] p,
                     input logic pr, input logic rd);
    int   sz;
    logic fb;
    @(negedge clk);
    commit_en  = c;
    result     = r;
    pc_in      = p;
    predict_en = pr;
    sys_rdy    = rd;
    #1;
    sz = mq.size();
    fb = (sz > 0) && !pr && rd;
    check("full",     32'(full),   32'(sz == DEPTH));
    check("count",    32'(count),  32'(sz));
    check("fb_en",    32'(fb_en),  32'(fb));
    check("fb_pc",    fb_pc,       (sz > 0) ? mq[0].pc : 32'h0);
    check("fb_res",   32'(fb_res), 32'((sz > 0) ? mq[0].t : 1'b0));
    check("stall",    32'(stall),  32'(m_starve == STARVE_LIMIT));
    check("overflow", 32'(ovf),    32'(m_ovf));
    if (rd) begin
      if (fb) void'(mq.pop_front());
      if (c) begin
        if (sz < DEPTH || fb) mq.push_back('{pc: p, t: r});
        else                  m_ovf = 1'b1;
      end
      if (fb || sz == 0)                 m_starve = 0;
      else if (m_starve < STARVE_LIMIT)  m_starve++;
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset applied between edges; outputs must clear without a clock
  task automatic do_reset();
    commit_en  = 1'b0;
    predict_en = 1'b0;
    rst_n      = 1'b0;
    #1;
    check("rst_full",  32'(full),   32'h0);
    check("rst_count", 32'(count),  32'h0);
    check("rst_fb_en", 32'(fb_en),  32'h0);
    check("rst_fb_pc", fb_pc,       32'h0);
    check("rst_res",   32'(fb_res), 32'h0);
    check("rst_stall", 32'(stall),  32'h0);
    check("rst_ovf",   32'(ovf),    32'h0);
    mq.delete();
    m_starve = 0;
    m_ovf    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    sys_rdy    = 1'b1;
    commit_en  = 1'b0;
    result     = 1'b0;
    pc_in      = '0;
    predict_en = 1'b0;
    #2;
    do_reset();

    // Single push then pop when the predictor is idle
    cyc(1, 1, 32'h1000, 0, 1);
    cyc(0, 0, 32'h0, 0, 1);
    cyc(0, 0, 32'h0, 0, 1);

    // Fill under prediction pressure, overflow on the ninth, then drain in order
    for (int i = 0; i < 9; i++) cyc(1, i[0], 32'(i * 4), 1, 1);
    for (int i = 0; i < 9; i++) cyc(0, 0, 32'h0, 0, 1);

    // Simultaneous push and pop while full
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, i[1], 32'(i * 4), 1, 1);
    cyc(1, 1, 32'h40, 0, 1);
    for (int i = 0; i < 9; i++) cyc(0, 0, 32'h0, 0, 1);

    // Starvation: one entry held off long enough to raise the stall request
    cyc(1, 0, 32'h2000, 1, 1);
    for (int i = 0; i < 11; i++) cyc(0, 0, 32'h0, 1, 1);
    cyc(0, 0, 32'h0, 0, 1);
    cyc(0, 0, 32'h0, 0, 1);

    // Global ready low freezes everything despite commits
    cyc(1, 1, 32'h3000, 1, 1);
    cyc(1, 0, 32'h3004, 1, 1);
    for (int i = 0; i < 3; i++) cyc(1, 1, 32'h3100, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 32'h0, 0, 1);

    // Reset mid-drain with five entries pending
    for (int i = 0; i < 7; i++) cyc(1, 1, 32'h4000 + 32'(i * 4), 1, 1);
    cyc(0, 0, 32'h0, 0, 1);
    cyc(0, 0, 32'h0, 0, 1);
    check("count_before_rst", 32'(count), 32'd5);
    do_reset();
    cyc(0, 0, 32'h0, 0, 1);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 1500; n++) begin
      logic c, r, pr, rd;
      c  = ($urandom_range(0, 99) < 55);
      r  = 1'($urandom_range(0, 1));
      pr = ($urandom_range(0, 99) < ((n / 250) % 2 == 0 ? 75 : 35));
      rd = ($urandom_range(0, 99) < 90);
      cyc(c, r, $urandom() & 32'hFFFF_FFFC, pr, rd);
      if ($urandom_range(0, 299) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
